// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_ctrl : five-stage pipeline sequencer (stalls, redirects, halt drain)
// Revision  : 1.0
// ============================================================================
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_ready,
  input  logic        m_busy,
  input  logic        d_valid,
  input  logic        d_halt,
  input  logic        d_rs_used,
  input  logic        d_rt_used,
  input  logic [2:0]  d_rs,
  input  logic [2:0]  d_rt,
  input  logic        x_valid,
  input  logic        x_load,
  input  logic [2:0]  x_rd,
  input  logic        x_redirect,
  input  logic        w_valid,
  input  logic        w_halt,
  output logic        pc_en,
  output logic        fd_en,
  output logic        fd_vin,
  output logic        de_en,
  output logic        de_vin,
  output logic        xm_en,
  output logic        xm_vin,
  output logic        mw_en,
  output logic        mw_vin,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        halted_q, halted_d;
  logic [15:0] cnt_q, cnt_d;
  logic        load_use, redirect;

  assign load_use = d_valid & x_valid & x_load &
                    ((d_rs_used & (d_rs == x_rd)) | (d_rt_used & (d_rt == x_rd)));
  assign redirect = x_redirect & x_valid;

  always_comb begin
    pc_en   = 1'b0;
    fd_en   = 1'b0;
    fd_vin  = 1'b0;
    de_en   = 1'b0;
    de_vin  = 1'b0;
    xm_en   = 1'b0;
    xm_vin  = 1'b0;
    mw_en   = 1'b0;
    mw_vin  = 1'b0;
    state_d = state_q;

    if (rst) begin
      unique case (state_q)
        RUN: begin
          if (m_busy) begin
            mw_en = 1'b1;
          end else if (redirect) begin
            pc_en  = 1'b1;
            fd_en  = 1'b1;
            de_en  = 1'b1;
            xm_en  = 1'b1;
            xm_vin = 1'b1;
            mw_en  = 1'b1;
            mw_vin = 1'b1;
          end else if (load_use) begin
            de_en  = 1'b1;
            xm_en  = 1'b1;
            xm_vin = 1'b1;
            mw_en  = 1'b1;
            mw_vin = 1'b1;
          end else if (!f_ready) begin
            fd_en  = 1'b1;
            de_en  = 1'b1;
            de_vin = 1'b1;
            xm_en  = 1'b1;
            xm_vin = 1'b1;
            mw_en  = 1'b1;
            mw_vin = 1'b1;
          end else begin
            pc_en  = 1'b1;
            fd_en  = 1'b1;
            fd_vin = 1'b1;
            de_en  = 1'b1;
            de_vin = 1'b1;
            xm_en  = 1'b1;
            xm_vin = 1'b1;
            mw_en  = 1'b1;
            mw_vin = 1'b1;
          end
          // HALT only leaves decode when decode actually advances into execute
          if (d_valid && d_halt && !m_busy && !redirect && !load_use)
            state_d = DRAIN;
        end
        DRAIN: begin
          fd_en = 1'b1;
          de_en = 1'b1;
          mw_en = 1'b1;
          if (!m_busy) begin
            xm_en  = 1'b1;
            xm_vin = 1'b1;
            mw_vin = 1'b1;
          end
          if (w_valid && w_halt)
            state_d = HALT;
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != HALT) && !pc_en && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  assign halted_d = (state_d == HALT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = cnt_q;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencer for the five-stage 16-bit core. Each cycle it drives the PC enable and the enable/valid-inject inputs of the four inter-stage registers (fetch/decode, decode/execute, execute/memory, memory/writeback). It resolves load-use stalls, branch redirects, instruction- and data-memory waits, and halt draining. It also keeps a saturating fetch-stall counter.

## Interface
Parameters:
- none (register file is fixed at 8 entries, 3-bit specifiers)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset: synchronous, active-low
- f_ready  in  1  instruction memory delivers a valid instruction this cycle
- m_busy  in  1  data memory has not completed the memory-stage access
- d_valid  in  1  decode stage holds a valid instruction
- d_halt  in  1  decode instruction is HALT
- d_rs_used, d_rt_used  in  1 each  decode reads rs / rt
- d_rs, d_rt  in  3 each  decode source register numbers
- x_valid  in  1  execute stage holds a valid instruction
- x_load  in  1  execute instruction is a load
- x_rd  in  3  execute destination register
- x_redirect  in  1  execute resolved a taken branch/jump; PC mux selects target
- w_valid, w_halt  in  1 each  writeback holds a valid HALT when both high
- pc_en  out  1  PC register load enable
- fd_en, fd_vin  out  1 each  fetch/decode enable, valid bit written
- de_en, de_vin  out  1 each  decode/execute enable, valid bit written
- xm_en, xm_vin  out  1 each  execute/memory enable, valid bit written
- mw_en, mw_vin  out  1 each  memory/writeback enable, valid bit written
- halted  out  1  core stopped
- stall_cnt  out  16  cycles in which fetch was held while not halted

## Operation
- FSM states: RUN, DRAIN, HALT. Outputs are combinational from state and inputs, except halted and stall_cnt, which are registered.
- Hazard terms:
  - lu = d_valid & x_valid & x_load & ((d_rs_used & d_rs==x_rd) | (d_rt_used & d_rt==x_rd)). r0 gets no special treatment.
  - rd = x_redirect & x_valid.
- Priority in RUN, highest first:
  1. m_busy: pc/fd/de/xm en=0; mw_en=1, mw_vin=0.
  2. rd: pc_en=1; fd_en=1, fd_vin=0; de_en=1, de_vin=0; xm, mw advance with vin=1.
  3. lu: pc_en=0, fd_en=0; de_en=1, de_vin=0; xm, mw advance.
  4. !f_ready: pc_en=0; fd_en=1, fd_vin=0; de, xm, mw advance.
  5. Otherwise all en=1, all vin=1.
- "Advance" means en=1, vin=1.
- RUN→DRAIN when d_valid & d_halt & no m_busy/rd/lu (HALT moves into execute). A HALT flushed by rd stays in RUN.
- DRAIN: pc_en=0; fd_en=1, fd_vin=0; de_en=1, de_vin=0. xm and mw follow the m_busy rule, otherwise advance. x_redirect and lu are ignored, since no older instruction can redirect.
- DRAIN→HALT when w_valid & w_halt.
- HALT: all en=0, all vin=0. halted=1. Leaves only on reset.
- stall_cnt increments when state≠HALT and pc_en=0. It saturates at 0xFFFF.

## Timing
- While rst=0: all en and vin outputs are 0. At the edge: state←RUN, halted←0, stall_cnt←0.
- Reset mid-operation (any state) gives RUN on the next edge. Pipeline registers clear themselves on the same reset.
- Redirect latency: x_redirect seen in cycle N gives target PC and two bubbles in fd/de after edge N. The target instruction reaches decode at N+2.
- Load-use: exactly one bubble. The dependent instruction enters execute one cycle late, once the load is in memory.
- m_busy held k cycles freezes stages 0-3 for k cycles and inserts k writeback bubbles.
- rd in the same cycle as lu or !f_ready: rd wins.
- m_busy in the same cycle as rd: freeze. rd is re-evaluated when m_busy drops, because execute is held.
- halted rises on the edge where DRAIN sees w_valid & w_halt.
- stall_cnt reflects a stalled cycle one edge later.

## Test plan
- Reset held 3 cycles, then f_ready=1 with no hazards → all en=1, all vin=1 every cycle; stall_cnt stays 0.
- d_rs=3, d_rs_used=1, x_load=1, x_rd=3, both valid → one cycle of pc_en=0, fd_en=0, de_vin=0; stall_cnt=1.
- x_redirect=1 together with lu and f_ready=0 → pc_en=1, fd_vin=0, de_vin=0; stall_cnt unchanged.
- m_busy high 4 cycles → pc/fd/de/xm en=0 and mw_vin=0 for 4 cycles; stall_cnt=4.
- d_halt enters, then w_halt arrives 3 cycles later → DRAIN with fd_vin=de_vin=0; halted=1 after the next edge; all en=0 thereafter.
- rst low while in HALT → halted=0 and stall_cnt=0 after the edge; normal flow resumes. Separately, 65540 stalled cycles → stall_cnt holds at 0xFFFF.
